// File: rtl/memory_stage.sv
// MEM stage: EX/MEM consumer, req/ack data-memory port, MEM/WB register.
// Optional abort of stuck accesses: define MEM_TIMEOUT_EN.
module memory_stage #(
  parameter int DATA_W         = 32,
  parameter int REG_W          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              PCSrcM,
  input  logic              RegWriteM,
  input  logic              MemToRegM,
  input  logic              MemWriteM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [REG_W-1:0]  WA3M,
  output logic              MemReq,
  output logic              MemWe,
  output logic [DATA_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemRData,
  output logic              StallM,
  output logic [DATA_W-1:0] ADataMem,
  output logic              PCSrcW,
  output logic              RegWriteW,
  output logic              MemToRegW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ALUOutW,
  output logic [REG_W-1:0]  WA3W,
  output logic [DATA_W-1:0] ResultW,
  output logic              MemErr
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t state_q, state_d;

  logic              access;
  logic              timeout;
  logic              load_done;
  logic              enter_wait;
  logic              addr_lat_we;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              we_q;

  assign access   = MemToRegM | MemWriteM;
  assign ADataMem = ALUResultM;

  always_comb begin
    state_d  = state_q;
    MemReq   = 1'b0;
    StallM   = 1'b0;
    MemWe    = MemWriteM;
    MemAddr  = ALUResultM;
    MemWData = WriteDataM;
    unique case (state_q)
      S_IDLE: begin
        MemReq = access;
        StallM = access & ~MemAck;
        if (access && !MemAck)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        MemWe    = we_q;
        MemAddr  = addr_q;
        MemWData = data_q;
        MemReq   = ~timeout;
        StallM   = ~MemAck & ~timeout;
        if (MemAck || timeout)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Reset kills an in-flight request without waiting for an edge
    if (!reset) begin
      MemReq = 1'b0;
      StallM = 1'b0;
    end
  end

  assign enter_wait  = (state_q == S_IDLE) && (state_d == S_WAIT);
  assign addr_lat_we = enter_wait;
  assign load_done   = MemReq & MemAck & MemToRegM;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (addr_lat_we) begin
        addr_q <= ALUResultM;
        data_q <= WriteDataM;
        we_q   <= MemWriteM;
      end
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      PCSrcW    <= 1'b0;
      RegWriteW <= 1'b0;
      MemToRegW <= 1'b0;
      ReadDataW <= '0;
      ALUOutW   <= '0;
      WA3W      <= '0;
    end else if (!StallM) begin
      PCSrcW    <= PCSrcM & ~timeout;
      RegWriteW <= RegWriteM & ~timeout;
      MemToRegW <= MemToRegM;
      ALUOutW   <= ALUResultM;
      WA3W      <= WA3M;
      if (load_done)
        ReadDataW <= MemRData;
    end else begin
      PCSrcW    <= 1'b0;
      RegWriteW <= 1'b0;
      MemToRegW <= 1'b0;
    end
  end

  assign ResultW = MemToRegW ? ReadDataW : ALUOutW;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  // Last permitted WAIT cycle doubles as the abort cycle
  assign timeout = (state_q == S_WAIT) && !MemAck &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign MemErr  = err_q;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (enter_wait)
        cnt_q <= '0;
      else if (state_q == S_WAIT)
        cnt_q <= cnt_q + 1'b1;
      if (timeout)
        err_q <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = |TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
  assign MemErr     = 1'b0;
`endif

endmodule
